// File: rtl/bscac7_dec_collect_pkg.sv
// Shared constants for the BSCAC 7-TSV link receive path.
package bscac7_dec_collect_pkg;
   localparam int               LANES          = 7;
   localparam int               DTSV_IDX       = 0;
   localparam logic [LANES-1:0] INIT_STATE_DEF = 7'b0;
endpackage

// File: rtl/bscac7_dec_collect_free_recover.sv
// Recovers which lanes the encoder read (free) from the previous and current TSV
// levels, and flags locked lanes whose level nevertheless changed.
module bscac7_free_recover
   import bscac7_dec_collect_pkg::*;
(
   input  logic [LANES-1:0] prev,
   input  logic [LANES-1:0] rx,
   output logic [LANES-1:0] free,
   output logic [LANES-1:1] lock_err
);
   logic [LANES-1:0] x;
   logic [LANES-1:1] p;
   logic [LANES-1:1] e;

   always_comb begin
      x = prev ~^ rx;
      p = '0;
      e = '0;
      for (int i = 1; i < LANES; i++) begin
         p[i] = prev[DTSV_IDX] ~^ prev[i];
         e[i] = prev[i] ~^ prev[i-1];
      end

      free           = '0;
      free[DTSV_IDX] = 1'b1;
      if (x[DTSV_IDX]) begin
         // DTSV held its level: a shielded lane is free if it or its lower neighbour allows it
         free[1] = 1'b1;
         for (int i = 2; i < LANES; i++)
            free[i] = e[i] | x[i-1];
      end else begin
         free[1] = p[1] | (~p[6] & ~p[2]) | (p[6] & p[2] & x[6] & x[2]);
         for (int i = 2; i <= 5; i++)
            free[i] = p[i] | (~p[i-1] & ~p[i+1]) | (~p[i-1] & ~x[i-1])
                    | (p[i-1] & p[i+1] & x[i-1] & x[i+1]);
         free[6] = p[6] | (~p[5] & ~p[1]) | (~p[5] & ~x[5]) | (~p[1] & ~x[1])
                 | (p[5] & p[1] & x[5] & x[1]);
      end

      lock_err = ~free[LANES-1:1] & ~x[LANES-1:1];
   end
endmodule

// File: rtl/bscac7_dec_collect.sv
// Receive-side collector: turns accepted TSV beats into per-lane words, each lane
// buffered in a 2-entry FIFO.
module bscac7_dec_collect
   import bscac7_dec_collect_pkg::*;
#(
   parameter int               DATA_W     = 8,
   parameter logic [LANES-1:0] INIT_STATE = INIT_STATE_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   input  logic [LANES-1:0]        tsv_rx,
   output logic [LANES*DATA_W-1:0] lane_data,
   output logic [LANES-1:0]        lane_valid,
   input  logic [LANES-1:0]        lane_ready,
   output logic                    err_lock
);
   localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic                    accept;
   logic [LANES-1:0]        prev_q, prev_d;
   logic [LANES-1:0]        free;
   logic [LANES-1:1]        lock_err;
   logic [LANES-1:0]        push;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        cnt_q  [LANES];
   logic [CNT_W-1:0]        cnt_d  [LANES];
   logic [DATA_W-1:0]       sh_q   [LANES];
   logic [DATA_W-1:0]       sh_d   [LANES];
   logic [DATA_W-1:0]       b0_q   [LANES];
   logic [DATA_W-1:0]       b0_d   [LANES];
   logic [DATA_W-1:0]       b1_q   [LANES];
   logic [DATA_W-1:0]       b1_d   [LANES];
   logic [1:0]              bcnt_q [LANES];
   logic [1:0]              bcnt_d [LANES];

   bscac7_free_recover u_free (
      .prev     (prev_q),
      .rx       (tsv_rx),
      .free     (free),
      .lock_err (lock_err)
   );

   // Ready depends only on buffer occupancy registers, never on lane_ready.
   always_comb begin
      rx_ready   = 1'b1;
      lane_valid = '0;
      lane_data  = '0;
      for (int k = 0; k < LANES; k++) begin
         if (bcnt_q[k] == 2'd2) rx_ready = 1'b0;
         lane_valid[k]                = (bcnt_q[k] != 2'd0);
         lane_data[k*DATA_W +: DATA_W] = b0_q[k];
      end
   end

   assign accept   = rx_valid & rx_ready;
   assign err_lock = err_q;

   always_comb begin
      prev_d = prev_q;
      err_d  = err_q;
      push   = '0;
      for (int k = 0; k < LANES; k++) begin
         cnt_d[k]  = cnt_q[k];
         sh_d[k]   = sh_q[k];
         b0_d[k]   = b0_q[k];
         b1_d[k]   = b1_q[k];
         bcnt_d[k] = bcnt_q[k];

         if (accept && free[k]) begin
            sh_d[k][cnt_q[k]] = tsv_rx[k];
            if (cnt_q[k] == CNT_LAST) begin
               cnt_d[k] = '0;
               push[k]  = 1'b1;
            end else begin
               cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
         end

         // Pop first, then push into the slot after the head; a push never meets a full buffer.
         if (lane_valid[k] && lane_ready[k]) begin
            b0_d[k]   = b1_q[k];
            bcnt_d[k] = bcnt_q[k] - 2'd1;
         end
         if (push[k]) begin
            if (bcnt_d[k] == 2'd0) b0_d[k] = sh_d[k];
            else                   b1_d[k] = sh_d[k];
            bcnt_d[k] = bcnt_d[k] + 2'd1;
         end
      end

      if (accept) begin
         prev_d = tsv_rx;
         if (|lock_err) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= INIT_STATE;
         err_q  <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            cnt_q[k]  <= '0;
            sh_q[k]   <= '0;
            b0_q[k]   <= '0;
            b1_q[k]   <= '0;
            bcnt_q[k] <= '0;
         end
      end else begin
         prev_q <= prev_d;
         err_q  <= err_d;
         for (int k = 0; k < LANES; k++) begin
            cnt_q[k]  <= cnt_d[k];
            sh_q[k]   <= sh_d[k];
            b0_q[k]   <= b0_d[k];
            b1_q[k]   <= b1_d[k];
            bcnt_q[k] <= bcnt_d[k];
         end
      end
   end
endmodule

// File: tb/tb_bscac7_dec_collect.sv
// Scoreboard bench for bscac7_dec_collect: directed beats push expected lane words,
// a negedge monitor pops and compares on every lane handshake.
module tb_bscac7_dec_collect;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rx_valid = 1'b0;
   logic [6:0]  tsv_rx = 7'h00;
   logic [6:0]  lane_ready = 7'h00;
   logic        rx_ready;
   logic [55:0] lane_data;
   logic [6:0]  lane_valid;
   logic        err_lock;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q [7][$];

   bscac7_dec_collect #(.DATA_W(8), .INIT_STATE(7'b0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tsv_rx     (tsv_rx),
      .lane_data  (lane_data),
      .lane_valid (lane_valid),
      .lane_ready (lane_ready),
      .err_lock   (err_lock)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 7; k++) begin
            if (lane_valid[k] && lane_ready[k]) begin
               if (exp_q[k].size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL lane%0d_unexpected: got word 0x%0h, expected none", k,
                           lane_data[k*8 +: 8]);
               end else begin
                  check($sformatf("lane%0d_word", k), 64'(lane_data[k*8 +: 8]),
                        64'(exp_q[k].pop_front()));
               end
            end
         end
      end
   end

   task automatic push_lane(input int k, input logic [7:0] w);
      exp_q[k].push_back(w);
   endtask

   task automatic push_all(input logic [7:0] w);
      for (int k = 0; k < 7; k++) exp_q[k].push_back(w);
   endtask

   // Entered at posedge+1; returns at posedge+1 after the beat is taken.
   task automatic beat(input logic [6:0] v);
      int g;
      g = 0;
      tsv_rx   = v;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (!rx_ready) check("beat_ready_timeout", 64'(rx_ready), 64'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      for (int k = 0; k < 7; k++) exp_q[k].delete();
      @(negedge clk);
      check("rst_lane_valid", 64'(lane_valid), 64'd0);
      check("rst_lane_data", 64'(lane_data), 64'd0);
      check("rst_err_lock", 64'(err_lock), 64'd0);
      check("rst_rx_ready", 64'(rx_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      lane_ready = 7'h7F;
      repeat (10) @(posedge clk);
      #1;
      for (int k = 0; k < 7; k++)
         check($sformatf("%s_lane%0d_left", nm, k), 64'(exp_q[k].size()), 64'd0);
      check({nm, "_valid_after"}, 64'(lane_valid), 64'd0);
   endtask

   initial begin
      #2;
      // 1: reset, then idle with junk on tsv_rx
      do_reset();
      tsv_rx = 7'h55;
      repeat (3) @(posedge clk);
      #1;
      tsv_rx = 7'h00;
      check("idle_lane_valid", 64'(lane_valid), 64'd0);
      check("idle_rx_ready", 64'(rx_ready), 64'd1);

      // 2: eight zero beats from reset, all lanes free
      lane_ready = 7'h00;
      repeat (7) beat(7'h00);
      check("t2_valid_7beats", 64'(lane_valid), 64'd0);
      push_all(8'h00);
      beat(7'h00);
      check("t2_valid_8beats", 64'(lane_valid), 64'h7F);
      check("t2_data", 64'(lane_data), 64'd0);
      check("t2_err", 64'(err_lock), 64'd0);
      drain("t2");

      // uniform beats keep every lane free: word 0xA5 LSB first on all lanes
      push_all(8'hA5);
      beat(7'h7F); beat(7'h00); beat(7'h7F); beat(7'h00);
      beat(7'h00); beat(7'h7F); beat(7'h00); beat(7'h7F);
      drain("a5");

      // 3: lane 2 locked on the second beat
      do_reset();
      lane_ready = 7'h00;
      push_lane(0, 8'h00); push_lane(1, 8'h01);
      push_lane(3, 8'h00); push_lane(4, 8'h00);
      push_lane(5, 8'h00); push_lane(6, 8'h00);
      beat(7'h02);
      beat(7'h00);
      repeat (6) beat(7'h00);
      check("t3_valid_lane2_short", 64'(lane_valid), 64'h7B);
      push_lane(2, 8'h00);
      beat(7'h00);
      check("t3_valid_lane2_done", 64'(lane_valid), 64'h7F);
      check("t3_err", 64'(err_lock), 64'd0);
      drain("t3");

      // 4: lane 1 locked without level change, then with change
      do_reset();
      beat(7'h02);
      beat(7'h43);
      check("t4_locked_no_err", 64'(err_lock), 64'd0);
      do_reset();
      beat(7'h02);
      beat(7'h41);
      check("t4_err_set", 64'(err_lock), 64'd1);
      beat(7'h00);
      beat(7'h7F);
      check("t4_err_sticky", 64'(err_lock), 64'd1);

      // 5: back-pressure from lane 0
      do_reset();
      lane_ready = 7'h7E;
      push_all(8'h00);
      push_all(8'h00);
      repeat (16) beat(7'h00);
      check("t5_rx_ready_full", 64'(rx_ready), 64'd0);
      tsv_rx   = 7'h01;
      rx_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rx_valid = 1'b0;
      tsv_rx   = 7'h00;
      check("t5_lane0_held", 64'(lane_valid[0]), 64'd1);
      check("t5_rx_ready_stall", 64'(rx_ready), 64'd0);
      lane_ready = 7'h7F;
      @(negedge clk);
      check("t5_no_comb_ready", 64'(rx_ready), 64'd0);
      @(posedge clk);
      #1;
      lane_ready = 7'h7E;
      check("t5_rx_ready_back", 64'(rx_ready), 64'd1);
      lane_ready = 7'h7F;
      push_all(8'h00);
      repeat (8) beat(7'h00);
      drain("t5");

      // 6: reset in the middle of a word
      do_reset();
      lane_ready = 7'h7F;
      beat(7'h7F); beat(7'h7F); beat(7'h7F);
      rst_n = 1'b0;
      for (int k = 0; k < 7; k++) exp_q[k].delete();
      #2;
      check("t6_valid_in_reset", 64'(lane_valid), 64'd0);
      check("t6_ready_in_reset", 64'(rx_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_all(8'h3C);
      beat(7'h00); beat(7'h00); beat(7'h7F); beat(7'h7F);
      beat(7'h7F); beat(7'h7F); beat(7'h00); beat(7'h00);
      drain("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
